shift_sequencer: RTL and testbench

Multi-cycle shift unit controller for the MIPS datapath. It executes SLL, SRL and SRA by stepping the operand through a shift-by-1 / shift-by-2 stage, at most 2 bit positions per cycle, instead of using a full barrel shifter. It uses a start/done handshake, so the main control unit can stall while it is busy. It sits beside the ALU and is fed by rt data and the shamt field.

---
 rtl/shift_seq_pkg.sv | 20 ++
 rtl/shift_sequencer_if.sv | 38 +++
 rtl/shift_step.sv | 42 ++++
 rtl/shift_sequencer.sv | 113 +++++++++++
 tb/tb_shift_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// -----------------------------------------------------------------------------
// shift_seq_pkg
// Shared encodings for the multi-cycle shift sequencer.
//   OP_*  : shift operation codes carried on op_i (2'b11 is reserved and
//           behaves as a logical right shift)
//   state_t : sequencer FSM states, 2-bit binary encoding
// -----------------------------------------------------------------------------
package shift_seq_pkg;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_t;

endpackage : shift_seq_pkg

// File: rtl/shift_sequencer_if.sv
// -----------------------------------------------------------------------------
// shift_sequencer_if
// Request/response bundle between the main control unit and the sequencer.
//   start_i  : request a shift (only honoured while idle)
//   op_i     : operation code (see shift_seq_pkg)
//   data_i   : operand, captured with start_i
//   shamt_i  : shift amount, captured with start_i
//   flush_i  : synchronous abort of an operation in flight
//   busy_o   : high whenever the sequencer is not idle
//   done_o   : one-cycle pulse, result_o valid in the same cycle
//   result_o : registered result, held until the next accepted start
// Modports: master (control unit side), slave (sequencer side).
// -----------------------------------------------------------------------------
interface shift_sequencer_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
);

   logic                   start_i;
   logic [1:0]             op_i;
   logic [DATA_WIDTH-1:0]  data_i;
   logic [SHAMT_WIDTH-1:0] shamt_i;
   logic                   flush_i;
   logic                   busy_o;
   logic                   done_o;
   logic [DATA_WIDTH-1:0]  result_o;

   modport master (
      output start_i, op_i, data_i, shamt_i, flush_i,
      input  busy_o, done_o, result_o
   );

   modport slave (
      input  start_i, op_i, data_i, shamt_i, flush_i,
      output busy_o, done_o, result_o
   );

endinterface : shift_sequencer_if

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Combinational single step of the shifter: moves data_i by one or two bit
// positions in the direction given by op_i.
//   data_i        : value to shift
//   op_i          : OP_SLL / OP_SRL / OP_SRA (reserved code acts as SRL)
//   two_not_one_i : 1 = shift by 2, 0 = shift by 1
//   data_o        : shifted value
// -----------------------------------------------------------------------------
module shift_step
   import shift_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [1:0]            op_i,
   input  logic                  two_not_one_i,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic sign;

   // The working register's MSB never changes under SRA, so it always equals
   // the original operand's sign bit.
   assign sign = data_i[DATA_WIDTH-1];

   always_comb begin
      // NOTE: every variable written in a combinational block gets a default
      // first, so no path through the block can leave it unassigned (latch).
      data_o = '0;
      case (op_i)
         OP_SLL:  data_o = two_not_one_i ? {data_i[DATA_WIDTH-3:0], 2'b00}
                                         : {data_i[DATA_WIDTH-2:0], 1'b0};
         OP_SRA:  data_o = two_not_one_i ? {{2{sign}}, data_i[DATA_WIDTH-1:2]}
                                         : {sign, data_i[DATA_WIDTH-1:1]};
         // OP_SRL and the reserved code both shift in zeros from the top.
         default: data_o = two_not_one_i ? {2'b00, data_i[DATA_WIDTH-1:2]}
                                         : {1'b0, data_i[DATA_WIDTH-1:1]};
      endcase
   end

endmodule : shift_step

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Multi-cycle SLL/SRL/SRA unit. The operand is stepped through shift_step at
// up to two bit positions per cycle; latency from the accepting edge to the
// done_o cycle is ceil(shamt/2)+1 edges.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : shift_sequencer_if slave (start/op/data/shamt/flush in,
//           busy/done/result out)
// All outputs are decoded from registers only.
// -----------------------------------------------------------------------------
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic              clk,
   input  logic              reset,
   shift_sequencer_if.slave  bus
);

   state_t                 state_q, state_d;
   logic [SHAMT_WIDTH-1:0] rem_q, rem_d;
   logic [DATA_WIDTH-1:0]  work_q, work_d;
   logic [1:0]             op_q, op_d;
   logic [DATA_WIDTH-1:0]  result_q, result_d;

   logic                   two_step;
   logic [DATA_WIDTH-1:0]  step_out;

   assign two_step = (rem_q > SHAMT_WIDTH'(1));

   // Amounts beyond DATA_WIDTH need no special case: repeated steps push every
   // original bit out, leaving zeros (SLL/SRL) or sign fill (SRA).
   shift_step #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_step (
      .data_i        (work_q),
      .op_i          (op_q),
      .two_not_one_i (two_step),
      .data_o        (step_out)
   );

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      work_d   = work_q;
      op_d     = op_q;
      result_d = result_q;

      case (state_q)
         S_IDLE: begin
            // flush_i wins over a simultaneous start_i.
            if (bus.start_i && !bus.flush_i) begin
               work_d = bus.data_i;
               op_d   = bus.op_i;
               rem_d  = bus.shamt_i;
               if (bus.shamt_i != '0) begin
                  state_d = S_SHIFT;
               end else begin
                  state_d  = S_DONE;
                  result_d = bus.data_i;
               end
            end
         end

         S_SHIFT: begin
            if (bus.flush_i) begin
               state_d = S_IDLE;
            end else begin
               work_d = step_out;
               rem_d  = two_step ? (rem_q - SHAMT_WIDTH'(2)) : '0;
               if (rem_d == '0) begin
                  state_d  = S_DONE;
                  result_d = step_out;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         rem_q    <= '0;
         work_q   <= '0;
         op_q     <= OP_SLL;
         result_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples its next value from the same pre-edge snapshot.
         state_q  <= state_d;
         rem_q    <= rem_d;
         work_q   <= work_d;
         op_q     <= op_d;
         result_q <= result_d;
      end
   end

   assign bus.busy_o   = (state_q != S_IDLE);
   assign bus.done_o   = (state_q == S_DONE);
   assign bus.result_o = result_q;

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
// Directed bench for shift_sequencer. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle away from the active
// rising edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;
   import shift_seq_pkg::*;

   logic clk;
   logic reset;

   int checks = 0;
   int passed = 0;
   int fails  = 0;
   int lat;
   int done_seen;

   shift_sequencer_if #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) bus ();

   shift_sequencer #(
      .DATA_WIDTH  (32),
      .SHAMT_WIDTH (5)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue a one-cycle start and return the number of edges from acceptance
   // up to and including the edge that raised done_o (bounded at 40).
   task automatic run(input logic [1:0] op, input logic [31:0] d,
                      input logic [4:0] s, output int n);
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.op_i    = op;
      bus.data_i  = d;
      bus.shamt_i = s;
      @(negedge clk);
      bus.start_i = 1'b0;
      n = 1;
      while (bus.done_o !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      reset       = 1'b0;
      bus.start_i = 1'b0;
      bus.op_i    = OP_SLL;
      bus.data_i  = '0;
      bus.shamt_i = '0;
      bus.flush_i = 1'b0;

      // Reset state
      #1;
      check("rst_busy",   32'(bus.busy_o), 32'd0);
      check("rst_done",   32'(bus.done_o), 32'd0);
      check("rst_result", bus.result_o,    32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("idle_busy", 32'(bus.busy_o), 32'd0);

      // SLL 1 << 2, stepped by hand
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.op_i    = OP_SLL;
      bus.data_i  = 32'h0000_0001;
      bus.shamt_i = 5'd2;
      @(negedge clk);
      bus.start_i = 1'b0;
      check("sll2_c1_busy", 32'(bus.busy_o), 32'd1);
      check("sll2_c1_done", 32'(bus.done_o), 32'd0);
      @(negedge clk);
      check("sll2_c2_busy", 32'(bus.busy_o), 32'd1);
      check("sll2_c2_done", 32'(bus.done_o), 32'd1);
      check("sll2_result",  bus.result_o,    32'h0000_0004);
      @(negedge clk);
      check("sll2_c3_busy", 32'(bus.busy_o), 32'd0);
      check("sll2_c3_done", 32'(bus.done_o), 32'd0);
      check("sll2_hold",    bus.result_o,    32'h0000_0004);

      // SRL by 31: longest latency
      run(OP_SRL, 32'h8000_0000, 5'd31, lat);
      check("srl31_lat",    32'(lat),        32'd17);
      check("srl31_result", bus.result_o,    32'h0000_0001);
      check("srl31_busy",   32'(bus.busy_o), 32'd1);
      @(negedge clk);
      check("srl31_busy_fall", 32'(bus.busy_o), 32'd0);

      // SRA, even and odd amounts
      run(OP_SRA, 32'h8000_0000, 5'd4, lat);
      check("sra4_lat",    32'(lat),     32'd3);
      check("sra4_result", bus.result_o, 32'hF800_0000);
      run(OP_SRA, 32'h7FFF_FFF0, 5'd3, lat);
      check("sra3_lat",    32'(lat),     32'd3);
      check("sra3_result", bus.result_o, 32'h0FFF_FFFE);

      // Reserved op behaves as SRL
      run(2'b11, 32'h8000_0001, 5'd1, lat);
      check("rsv_lat",    32'(lat),     32'd2);
      check("rsv_result", bus.result_o, 32'h4000_0000);

      // Zero shift amount
      run(OP_SLL, 32'hDEAD_BEEF, 5'd0, lat);
      check("sh0_lat",    32'(lat),     32'd1);
      check("sh0_result", bus.result_o, 32'hDEAD_BEEF);

      // Start while busy is ignored; start in the done cycle is ignored too
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.op_i    = OP_SRL;
      bus.data_i  = 32'hFFFF_FFFF;
      bus.shamt_i = 5'd8;
      @(negedge clk);
      bus.op_i    = OP_SLL;
      bus.data_i  = 32'h0000_0001;
      bus.shamt_i = 5'd0;
      @(negedge clk);
      bus.start_i = 1'b0;
      lat = 2;
      while (bus.done_o !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("busy_ign_lat",    32'(lat),     32'd5);
      check("busy_ign_result", bus.result_o, 32'h00FF_FFFF);
      bus.start_i = 1'b1;
      bus.op_i    = OP_SLL;
      bus.data_i  = 32'h1234_5678;
      bus.shamt_i = 5'd0;
      @(negedge clk);
      check("done_ign_busy", 32'(bus.busy_o), 32'd0);
      check("done_ign_hold", bus.result_o,    32'h00FF_FFFF);
      @(negedge clk);
      bus.start_i = 1'b0;
      check("next_start_done",   32'(bus.done_o), 32'd1);
      check("next_start_result", bus.result_o,    32'h1234_5678);

      // flush_i beats start_i in IDLE
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.flush_i = 1'b1;
      bus.data_i  = 32'hAAAA_AAAA;
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.flush_i = 1'b0;
      check("idle_flush_busy", 32'(bus.busy_o), 32'd0);
      check("idle_flush_hold", bus.result_o,    32'h1234_5678);

      // Flush mid-SHIFT
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.op_i    = OP_SLL;
      bus.data_i  = 32'h0000_0001;
      bus.shamt_i = 5'd20;
      @(negedge clk);
      bus.start_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.flush_i = 1'b1;
      @(negedge clk);
      bus.flush_i = 1'b0;
      check("flush_busy", 32'(bus.busy_o), 32'd0);
      check("flush_done", 32'(bus.done_o), 32'd0);
      check("flush_hold", bus.result_o,    32'h1234_5678);
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.done_o === 1'b1) done_seen++;
      end
      check("flush_no_done", 32'(done_seen), 32'd0);

      // Reset mid-SHIFT
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.op_i    = OP_SRA;
      bus.data_i  = 32'h8000_0000;
      bus.shamt_i = 5'd20;
      @(negedge clk);
      bus.start_i = 1'b0;
      check("pre_rst_busy", 32'(bus.busy_o), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_busy",   32'(bus.busy_o), 32'd0);
      check("midrst_done",   32'(bus.done_o), 32'd0);
      check("midrst_result", bus.result_o,    32'h0);
      @(negedge clk);
      reset = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.done_o === 1'b1) done_seen++;
      end
      check("midrst_no_done", 32'(done_seen), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule : tb_shift_sequencer
